// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 encodings and the
// divider state machine encoding.
package mdu_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divstate_t;

endpackage

// File: rtl/divstep.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract
// the divisor from the widened remainder, keep or restore, and emit a quotient bit.
module divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] R,
    input  logic [XLEN-1:0] Q,
    input  logic [XLEN-1:0] D,
    output logic [XLEN-1:0] Rnext,
    output logic [XLEN-1:0] Qnext
);

    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            neg;
    logic            unused_diff;

    // R < D holds between steps, so the kept difference always fits in XLEN bits.
    always_comb begin
        shifted = {R, Q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, D};
        neg     = diff[XLEN+1];
        Rnext   = neg ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        Qnext   = {Q[XLEN-2:0], ~neg};
    end

    assign unused_diff = diff[XLEN];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Holds Execute busy
// while iterating one quotient bit per cycle, then registers Q/R into Memory.
module div_iter
    import mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DIVCNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic            StallM,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic [2:0]      Funct3E,
    output logic            DivBusyE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] QuotM,
    output logic [XLEN-1:0] RemM
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    divstate_t          state_reg;
    logic [DIVCNTW-1:0] cnt_reg;
    logic [XLEN-1:0]    rem_reg;
    logic [XLEN-1:0]    quo_reg;
    logic [XLEN-1:0]    dvs_reg;
    logic               negq_reg;
    logic               negr_reg;
    logic               special_reg;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    abs_a;
    logic [XLEN-1:0]    abs_b;
    logic               b_zero;
    logic               ovf;
    logic [XLEN-1:0]    rem_step;
    logic [XLEN-1:0]    quo_step;
    logic [XLEN-1:0]    q_final;
    logic [XLEN-1:0]    r_final;
    logic               unused_funct3;

    // Bits [2:1] only select which result the pipeline consumes; both are produced.
    assign unused_funct3 = ^Funct3E[2:1];

    always_comb begin
        is_signed = ~Funct3E[0];
        a_neg     = is_signed & ForwardedSrcAE[XLEN-1];
        b_neg     = is_signed & ForwardedSrcBE[XLEN-1];
        abs_a     = a_neg ? (~ForwardedSrcAE + 1'b1) : ForwardedSrcAE;
        abs_b     = b_neg ? (~ForwardedSrcBE + 1'b1) : ForwardedSrcBE;
        b_zero    = (ForwardedSrcBE == '0);
        ovf       = is_signed & (ForwardedSrcAE == MOST_NEG) & (ForwardedSrcBE == '1);
    end

    divstep #(
        .XLEN (XLEN)
    ) u_divstep (
        .R     (rem_reg),
        .Q     (quo_reg),
        .D     (dvs_reg),
        .Rnext (rem_step),
        .Qnext (quo_step)
    );

    // Special-case results are stored final and must skip the sign fix.
    always_comb begin
        q_final = quo_reg;
        r_final = rem_reg;
        if (!special_reg) begin
            if (negq_reg) q_final = ~quo_reg + 1'b1;
            if (negr_reg) r_final = ~rem_reg + 1'b1;
        end
    end

    // Busy must rise in the start cycle itself so Execute stalls immediately.
    always_comb begin
        DivBusyE = 1'b0;
        case (state_reg)
            IDLE:    DivBusyE = StartE;
            BUSY:    DivBusyE = 1'b1;
            default: DivBusyE = 1'b0;
        endcase
    end

    assign DivDoneE = (state_reg == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            negq_reg    <= 1'b0;
            negr_reg    <= 1'b0;
            special_reg <= 1'b0;
            QuotM       <= '0;
            RemM        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (StartE) begin
                        negq_reg    <= is_signed & (ForwardedSrcAE[XLEN-1] ^ ForwardedSrcBE[XLEN-1]);
                        negr_reg    <= a_neg;
                        dvs_reg     <= abs_b;
                        cnt_reg     <= DIVCNTW'(XLEN);
                        special_reg <= b_zero | ovf;
                        if (b_zero) begin
                            quo_reg   <= '1;
                            rem_reg   <= ForwardedSrcAE;
                            state_reg <= DONE;
                        end else if (ovf) begin
                            quo_reg   <= ForwardedSrcAE;
                            rem_reg   <= '0;
                            state_reg <= DONE;
                        end else begin
                            quo_reg   <= abs_a;
                            rem_reg   <= '0;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (FlushE) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        cnt_reg <= cnt_reg - 1'b1;
                        if (cnt_reg == DIVCNTW'(1)) state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (FlushE) begin
                        state_reg <= IDLE;
                    end else if (!StallM) begin
                        QuotM     <= q_final;
                        RemM      <= r_final;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
